sgd_loss_monitor: RTL

// - Downstream of the SGD weight-update core. Consumes its per-sample error stream (Y - Y_CAP) and squares each error in fixed point.
// - Accumulates the squared errors over one epoch of DP samples and emits the epoch MSE.
// - Counts epochs and raises halt to freeze training on convergence (MSE <= THRESH) or when MAX_EPOCHS is reached.

---
 rtl/sgd_loss_monitor.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/sgd_loss_monitor.sv
// Squares the SGD error stream, accumulates one epoch of DP samples into an MSE and halts training
// on convergence or epoch limit. Define PATIENCE_EN to add best-loss tracking and a stall halt.
module sgd_loss_monitor #(
  parameter int unsigned          BITS       = 16,
  parameter int unsigned          FRAC       = 8,
  parameter int unsigned          DP         = 4,
  parameter int unsigned          LOG2_DP    = 2,
  parameter int unsigned          ACC_BITS   = 32,
  parameter logic [ACC_BITS-1:0]  THRESH     = 32'h10,
  parameter int unsigned          MAX_EPOCHS = 1000,
  parameter int unsigned          EPOCH_W    = 16,
  parameter int unsigned          PATIENCE   = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                start,
  input  logic                err_valid,
  input  logic [BITS-1:0]     err_in,
  output logic                err_ready,
  output logic                loss_valid,
  output logic [ACC_BITS-1:0] loss_out,
  output logic [EPOCH_W-1:0]  epoch_cnt,
  output logic                halt,
  output logic                converged,
  output logic                stalled,
  output logic                overrun
);

  localparam int unsigned ProdW = 2 * BITS;
  localparam int unsigned SumW  = ((ProdW > ACC_BITS) ? ProdW : ACC_BITS) + 1;
  localparam int unsigned CntW  = LOG2_DP + 1;

  typedef enum logic [2:0] {StIdle, StRun, StDrain, StReduce, StDone} state_e;

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [1:0]                 drain_q, drain_d;
  logic                       s1_valid_q, s1_valid_d;
  logic signed [BITS-1:0]     s1_err_q, s1_err_d;
  logic                       s2_valid_q, s2_valid_d;
  logic [ProdW-1:0]           s2_sq_q, s2_sq_d;
  logic [ACC_BITS-1:0]        acc_q, acc_d;
  logic                       loss_valid_q, loss_valid_d;
  logic [ACC_BITS-1:0]        loss_out_q, loss_out_d;
  logic [EPOCH_W-1:0]         epoch_q, epoch_d;
  logic                       conv_q, conv_d;
  logic                       overrun_q, overrun_d;

  logic                       accept;
  logic signed [ProdW-1:0]    err_ext, prod;
  logic [ProdW-1:0]           sq;
  logic [SumW-1:0]            sum;
  logic [ACC_BITS-1:0]        acc_sat;
  logic [ACC_BITS-1:0]        mse;
  logic [EPOCH_W-1:0]         epoch_inc;

`ifdef PATIENCE_EN
  localparam int unsigned StallW = $clog2(PATIENCE + 1);
  logic [ACC_BITS-1:0] best_q, best_d;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d, stall_cnt_nx;
  logic                stalled_q, stalled_d;
  logic                improved;
`endif

  assign err_ready  = (state_q == StRun);
  assign halt       = (state_q == StDone);
  assign accept     = err_valid && err_ready;
  assign loss_valid = loss_valid_q;
  assign loss_out   = loss_out_q;
  assign epoch_cnt  = epoch_q;
  assign converged  = conv_q;
  assign overrun    = overrun_q;

  // Square of a signed value is non-negative, so the shifted product fits unsigned.
  assign err_ext = ProdW'(s1_err_q);
  assign prod    = err_ext * err_ext;
  assign sq      = prod >>> FRAC;

  assign sum     = SumW'(acc_q) + SumW'(s2_sq_q);
  assign acc_sat = (|sum[SumW-1:ACC_BITS]) ? '1 : sum[ACC_BITS-1:0];

  assign mse       = acc_q >> LOG2_DP;
  assign epoch_inc = epoch_q + EPOCH_W'(1);

`ifdef PATIENCE_EN
  assign improved     = (mse < best_q);
  assign stall_cnt_nx = improved ? '0 : stall_cnt_q + StallW'(1);
  assign stalled      = stalled_q;
`else
  logic unused_patience;
  assign unused_patience = ^PATIENCE;
  assign stalled         = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    drain_d      = drain_q;
    s1_valid_d   = accept;
    s1_err_d     = accept ? err_in : s1_err_q;
    s2_valid_d   = s1_valid_q;
    s2_sq_d      = s1_valid_q ? sq : s2_sq_q;
    acc_d        = s2_valid_q ? acc_sat : acc_q;
    loss_valid_d = 1'b0;
    loss_out_d   = loss_out_q;
    epoch_d      = epoch_q;
    conv_d       = conv_q;
    overrun_d    = overrun_q;
`ifdef PATIENCE_EN
    best_d       = best_q;
    stall_cnt_d  = stall_cnt_q;
    stalled_d    = stalled_q;
`endif

    if (err_valid && !err_ready && (state_q inside {StRun, StDrain, StReduce})) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
      end
      StRun: begin
        if (accept) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DP - 1)) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end
      end
      StDrain: begin
        // Three cycles covers S1 -> S2 -> acc for the final sample.
        if (drain_q == 2'd2) state_d = StReduce;
        else                 drain_d = drain_q + 2'd1;
      end
      StReduce: begin
        loss_out_d   = mse;
        loss_valid_d = 1'b1;
        epoch_d      = epoch_inc;
`ifdef PATIENCE_EN
        stall_cnt_d  = stall_cnt_nx;
        if (improved) best_d = mse;
`endif
        if (mse <= THRESH) begin
          conv_d  = 1'b1;
          state_d = StDone;
        end
`ifdef PATIENCE_EN
        else if (stall_cnt_nx == StallW'(PATIENCE)) begin
          stalled_d = 1'b1;
          state_d   = StDone;
        end
`endif
        else if (epoch_inc == EPOCH_W'(MAX_EPOCHS)) begin
          state_d = StDone;
        end else begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StDone: begin
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d      = StRun;
      cnt_d        = '0;
      drain_d      = '0;
      s1_valid_d   = 1'b0;
      s2_valid_d   = 1'b0;
      acc_d        = '0;
      loss_valid_d = 1'b0;
      loss_out_d   = '0;
      epoch_d      = '0;
      conv_d       = 1'b0;
      overrun_d    = 1'b0;
`ifdef PATIENCE_EN
      best_d       = '1;
      stall_cnt_d  = '0;
      stalled_d    = 1'b0;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      drain_q      <= '0;
      s1_valid_q   <= 1'b0;
      s1_err_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_sq_q      <= '0;
      acc_q        <= '0;
      loss_valid_q <= 1'b0;
      loss_out_q   <= '0;
      epoch_q      <= '0;
      conv_q       <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef PATIENCE_EN
      best_q       <= '1;
      stall_cnt_q  <= '0;
      stalled_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      drain_q      <= drain_d;
      s1_valid_q   <= s1_valid_d;
      s1_err_q     <= s1_err_d;
      s2_valid_q   <= s2_valid_d;
      s2_sq_q      <= s2_sq_d;
      acc_q        <= acc_d;
      loss_valid_q <= loss_valid_d;
      loss_out_q   <= loss_out_d;
      epoch_q      <= epoch_d;
      conv_q       <= conv_d;
      overrun_q    <= overrun_d;
`ifdef PATIENCE_EN
      best_q       <= best_d;
      stall_cnt_q  <= stall_cnt_d;
      stalled_q    <= stalled_d;
`endif
    end
  end

endmodule
